bu_pred_fb: RTL

Branch-unit side of the predictor feedback interface. Holds, in program order, the prediction fetch made for each in-flight branch, and checks it against the actual outcome when the branch resolves in execute. Produces the registered `bu_*_q` feedback/allocate stream the branch predictor consumes, plus the front-end redirect on misprediction. Sits between the decode-stage branch tag and the execute-stage branch unit.

---
 rtl/bu_pred_fb.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bu_pred_fb.sv
// bu_pred_fb: in-order prediction queue checked at branch resolve; drives predictor feedback and redirect.
// Define BU_PRED_STATS_EN to build the saturating resolve/mispredict counters.
package riscv_pkg;
    localparam int XLEN = 32;
endpackage

module bu_pred_fb
    import riscv_pkg::*;
#(
    parameter int PQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            dec_br_v_i,
    input  logic [XLEN-1:0] dec_br_pc_i,
    input  logic            dec_pred_v_i,
    input  logic            dec_pred_taken_i,
    input  logic [XLEN-1:0] dec_pred_pc_i,
    output logic            pq_full_o,
    input  logic            ex_br_v_i,
    input  logic [XLEN-1:0] ex_br_pc_i,
    input  logic            ex_taken_i,
    input  logic [XLEN-1:0] ex_target_i,
    output logic            pred_en_o,
    output logic [XLEN-1:0] bu_pc_branch_o,
    output logic [XLEN-1:0] bu_pc_target_o,
    output logic            bu_pred_feedback_q_o,
    output logic            bu_pred_success_q_o,
    output logic            bu_pred_failed_q_o,
    output logic            flush_o,
    output logic [XLEN-1:0] flush_pc_o,
    output logic [31:0]     stat_br_o,
    output logic [31:0]     stat_mis_o
);
    localparam int AW = $clog2(PQ_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            pv;
        logic            pt;
        logic [XLEN-1:0] ppc;
    } ent_t;

    ent_t            ent_q [PQ_DEPTH];
    ent_t            head;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push, pop, hit, pv, pt, mis;
    logic [XLEN-1:0] fpc;
    logic            fb_q, fb_d, succ_q, succ_d, fail_q, fail_d, pen_q, pen_d, flush_q, flush_d;
    logic [XLEN-1:0] pcb_q, pcb_d, pct_q, pct_d, fpc_q, fpc_d;

    assign pq_full_o = cnt_q == CW'(PQ_DEPTH);
    assign pop       = ex_br_v_i & (cnt_q != '0);
    // A full queue still accepts a push when a pop frees a slot in the same cycle.
    assign push      = dec_br_v_i & (~pq_full_o | ex_br_v_i) & ~flush_q;
    assign head      = ent_q[rd_ptr_q];
    assign hit       = pop & (head.pc == ex_br_pc_i);
    assign pv        = hit & head.pv;
    assign pt        = pv & head.pt;
    assign mis       = (pt != ex_taken_i) | (pt & ex_taken_i & (head.ppc != ex_target_i));
    assign fpc       = ex_taken_i ? ex_target_i : ex_br_pc_i + XLEN'(4);

    always_comb begin
        rd_ptr_d = flush_q ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = flush_q ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        cnt_d    = flush_q ? '0 : cnt_q + CW'(push) - CW'(pop);
        fb_d     = ex_br_v_i;
        succ_d   = ex_br_v_i & ex_taken_i & pv;
        fail_d   = ex_br_v_i & ~ex_taken_i & pv;
        pen_d    = ex_br_v_i & ex_taken_i & ~pv;
        flush_d  = ex_br_v_i & mis;
        pcb_d    = ex_br_v_i ? ex_br_pc_i : pcb_q;
        pct_d    = ex_br_v_i ? ex_target_i : pct_q;
        fpc_d    = ex_br_v_i ? fpc : fpc_q;
    end

    always_ff @(posedge clk) begin
        if (push)
            ent_q[wr_ptr_q] <= '{pc: dec_br_pc_i, pv: dec_pred_v_i, pt: dec_pred_taken_i, ppc: dec_pred_pc_i};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            fb_q     <= 1'b0;
            succ_q   <= 1'b0;
            fail_q   <= 1'b0;
            pen_q    <= 1'b0;
            flush_q  <= 1'b0;
            pcb_q    <= '0;
            pct_q    <= '0;
            fpc_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            fb_q     <= fb_d;
            succ_q   <= succ_d;
            fail_q   <= fail_d;
            pen_q    <= pen_d;
            flush_q  <= flush_d;
            pcb_q    <= pcb_d;
            pct_q    <= pct_d;
            fpc_q    <= fpc_d;
        end
    end

    assign bu_pred_feedback_q_o = fb_q;
    assign bu_pred_success_q_o  = succ_q;
    assign bu_pred_failed_q_o   = fail_q;
    assign pred_en_o            = pen_q;
    assign flush_o              = flush_q;
    assign bu_pc_branch_o       = pcb_q;
    assign bu_pc_target_o       = pct_q;
    assign flush_pc_o           = fpc_q;

`ifdef BU_PRED_STATS_EN
    logic [31:0] stat_br_q, stat_br_d, stat_mis_q, stat_mis_d;

    always_comb begin
        stat_br_d  = (ex_br_v_i & (stat_br_q != '1)) ? stat_br_q + 32'd1 : stat_br_q;
        stat_mis_d = (flush_d & (stat_mis_q != '1)) ? stat_mis_q + 32'd1 : stat_mis_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_br_o  = stat_br_q;
    assign stat_mis_o = stat_mis_q;
`else
    assign stat_br_o  = '0;
    assign stat_mis_o = '0;
`endif
endmodule
